// File: rtl/tone_pkg.sv
// Shared types for the tone direction sequencer: command codes, FSM states,
// and tone-index helpers.
package tone_pkg;

  localparam int NUM_TONES = 5;
  localparam int NUM_PB    = 4;
  localparam int IDX_W     = 3;

  typedef enum logic [2:0] {
    STRAIGHT = 3'b000,
    LEFT     = 3'b001,
    RIGHT    = 3'b010,
    BACK     = 3'b011,
    STOP     = 3'b100
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    QUALIFY,
    ISSUE,
    HOLD
  } state_t;

  // Tone index 0..4 follows detector order: STOP has the highest priority.
  function automatic dir_t tone_dir(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    tone_dir = STOP;
      3'd1:    tone_dir = STRAIGHT;
      3'd2:    tone_dir = LEFT;
      3'd3:    tone_dir = RIGHT;
      3'd4:    tone_dir = BACK;
      default: tone_dir = STOP;
    endcase
  endfunction

  // Returns NUM_TONES when nothing is set, which never compares below a
  // valid candidate index.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_TONES-1:0] v);
    lowest_set = IDX_W'(NUM_TONES);
    for (int i = NUM_TONES - 1; i >= 0; i--)
      if (v[i]) lowest_set = IDX_W'(i);
  endfunction

endpackage

// File: rtl/tone_sync.sv
// Parameterized-width two-flop synchronizer, async active-low reset to 0.
module tone_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tone_dir_sequencer.sv
// Tone detector to drive-command sequencer: priority pick, dwell qualify,
// valid/ready issue, hold-off. Define TONE_MANUAL_EN to enable pushbuttons.
module tone_dir_sequencer
  import tone_pkg::*;
#(
  parameter int DWELL_CYCLES = 12_500_000,
  parameter int HOLD_CYCLES  = 25_000_000,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_TONES-1:0] bp,
  input  logic [NUM_PB-1:0]    pb,
  output logic [2:0]           dir_out,
  output logic                 dir_valid,
  input  logic                 dir_ready,
  output logic                 busy,
  output logic [NUM_TONES-1:0] led
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  logic [NUM_TONES-1:0] bp_s;
  logic [NUM_PB-1:0]    pb_rise;

  tone_sync #(.W(NUM_TONES)) u_bp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bp),
    .q     (bp_s)
  );

`ifdef TONE_MANUAL_EN
  logic [NUM_PB-1:0] pb_s, pb_q;

  tone_sync #(.W(NUM_PB)) u_pb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pb),
    .q     (pb_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pb_q <= '0;
    else        pb_q <= pb_s;
  end

  assign pb_rise = pb_s & ~pb_q;
`else
  logic unused_pb;
  assign unused_pb = ^pb;
  assign pb_rise   = '0;
`endif

  logic [IDX_W-1:0] bp_low, pb_src;

  assign bp_low = lowest_set(bp_s);
  // Button k drives the same command as tone k+1.
  assign pb_src = IDX_W'(lowest_set({1'b0, pb_rise}) + 3'd1);

  state_t           state;
  logic [IDX_W-1:0] cand;
  logic [CNT_W-1:0] dwell, hold;
  dir_t             dir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= '0;
      dwell     <= '0;
      hold      <= '0;
      dir_q     <= STOP;
      dir_valid <= 1'b0;
      busy      <= 1'b0;
      led       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bp_s) begin
            cand  <= bp_low;
            dwell <= CNT_W'(1);
            busy  <= 1'b1;
            state <= QUALIFY;
          end else if (|pb_rise) begin
            cand      <= pb_src;
            dir_q     <= tone_dir(pb_src);
            dir_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        QUALIFY: begin
          // A higher-priority tone preempts even if the candidate dropped.
          if (bp_low < cand) begin
            cand  <= bp_low;
            dwell <= CNT_W'(1);
          end else if (bp_s[cand]) begin
            if (dwell == DWELL_LAST) begin
              dir_q     <= tone_dir(cand);
              dir_valid <= 1'b1;
              dwell     <= '0;
              state     <= ISSUE;
            end else begin
              dwell <= dwell + CNT_W'(1);
            end
          end else begin
            dwell <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (dir_ready) begin
            led       <= NUM_TONES'(1) << cand;
            dir_valid <= 1'b0;
            hold      <= '0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (hold == HOLD_LAST) begin
            hold  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold <= hold + CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dir_out = dir_q;

endmodule

// File: doc/tone_dir_sequencer.md
# tone_dir_sequencer

Sequencing controller between the five band-pass tone detector outputs and the drive controller. It synchronizes the detector lines and picks one tone by fixed priority. The tone is qualified with a single shared dwell counter, then issued as a direction command over a valid/ready handshake. A hold-off window follows each command so a lingering tone cannot flood the drive controller.

## Interface
- DWELL_CYCLES, 12_500_000: consecutive synchronized high samples required to qualify a tone; legal range ≥ 2.
- HOLD_CYCLES, 25_000_000: lockout length after each accepted command; legal range ≥ 1.
- CNT_W, 32: width of the dwell and hold counters; must hold max(DWELL_CYCLES, HOLD_CYCLES).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- bp  in  5  raw band-pass detector outputs; bp[0]=STOP, [1]=STRAIGHT, [2]=LEFT, [3]=RIGHT, [4]=BACK.
- pb  in  4  raw manual pushbuttons mapped to STRAIGHT, LEFT, RIGHT, BACK (pb[0]..pb[3]).
- dir_out  out  3  command code: STOP 3'b100, STRAIGHT 3'b000, LEFT 3'b001, RIGHT 3'b010, BACK 3'b011.
- dir_valid  out  1  command valid.
- dir_ready  in  1  drive controller accepts the command.
- busy  out  1  high in every state except IDLE.
- led  out  5  one-hot index of the last accepted command source.

## Operation
- bp and pb each pass through a 2-flop synchronizer. All decisions below use the synchronized values.
- States: IDLE, QUALIFY, ISSUE, HOLD. Reset puts the block in IDLE.
- Reset values: dir_out=3'b100, dir_valid=0, busy=0, led=0, both counters 0.
- IDLE: if any bp is high, latch the lowest set index as the candidate, set dwell=1 and go to QUALIFY. Otherwise stay in IDLE.
- QUALIFY:
  - candidate high and dwell==DWELL_CYCLES-1: load dir_out with the candidate's code and go to ISSUE.
  - candidate high otherwise: dwell+1.
  - candidate low: go to IDLE and clear dwell.
  - a higher-priority bp high (lower index): it becomes the candidate, dwell=1, and the state stays QUALIFY. This takes precedence over the candidate-low rule.
  - lower-priority bp activity is ignored.
- ISSUE:
  - dir_valid=1. dir_out stays stable until the handshake.
  - Handshake = dir_valid & dir_ready at a rising edge. On that edge: led gets the one-hot of the source, hold=0, and the state goes to HOLD.
  - No timeout; new bp activity is ignored.
- HOLD: dir_valid=0 and all inputs are ignored. hold+1 each cycle; when hold==HOLD_CYCLES-1 the next state is IDLE. A tone still present afterwards requalifies from scratch and reissues.
- dir_out keeps the last issued code outside ISSUE.
- Reset mid-operation: every state and output returns to its reset value immediately. A pending command is dropped.

## Timing
- Raw bp rising to first sample in IDLE: 2 cycles of synchronizer latency.
- First high sample in IDLE at edge T: dir_valid is high from the edge T+DWELL_CYCLES-1 onward, as long as the candidate stays high through samples T..T+DWELL_CYCLES-1.
- Handshake at edge H: dir_valid is low after H. The earliest next QUALIFY entry is edge H+HOLD_CYCLES+1.
- Simultaneous bp edges: the lowest index wins. STOP (bp[0]) always wins.
- Counters never wrap: they are cleared on every exit from their state.

## Configuration
- TONE_MANUAL_EN defined:
  - In IDLE only, a synchronized rising edge on pb[k] bypasses QUALIFY. It loads dir_out with that button's code and goes straight to ISSUE; led = one-hot bit k+1.
  - pb edge detection is done on the synchronized pb against a registered copy.
  - A bp high in the same cycle takes priority over pb.
- TONE_MANUAL_EN undefined: pb stays in the port list but is unconnected internally. The synchronizer and edge logic are not built, and behaviour is tone-only.

## Structure
- Package tone_pkg holds:
  - the dir_t codes: STOP, STRAIGHT, LEFT, RIGHT, BACK;
  - the state enum (IDLE, QUALIFY, ISSUE, HOLD);
  - the tone-index-to-dir_t lookup function.
- Sub-module tone_sync: parameterized-width 2-flop synchronizer, asynchronous active-low reset to 0. It is instantiated for bp, and for pb under TONE_MANUAL_EN.

## Test plan
Bench uses DWELL_CYCLES=4, HOLD_CYCLES=8, and dir_ready tied high unless stated.
- bp[2] held high: dir_valid rises 2+3 cycles after the bp edge with dir_out=3'b001. After the handshake led=5'b00100 and dir_valid stays low for 8 cycles.
- bp[3] high for 2 synchronized samples, then low: no dir_valid, return to IDLE, busy falls.
- bp[4] qualifying, then bp[0] rises at dwell=2: requalification restarts and dir_out=3'b100 is issued 4 samples after bp[0].
- dir_ready low for 10 cycles during ISSUE: dir_valid and dir_out stay stable. They are accepted on the first ready edge and the block enters HOLD.
- rst_n pulsed low during HOLD: outputs return to reset values asynchronously and the block is in IDLE after release.
- With TONE_MANUAL_EN, pb[1] pulsed for 1 raw cycle in IDLE: dir_valid=1 with dir_out=3'b001 three cycles later and led=5'b00100. Without the macro: no response.
